flash_word_loader: RTL and testbench

- Responder side of the weight-load request interface (start / start_addr / byte_num in; load_en / load_data out).
- Accepts one load request and issues a single burst read to the SPI flash byte reader.
- Packs the returned byte stream into 256-bit words and delivers each word to the requester.
- load_data follows load_en by exactly one cycle.

---
 rtl/flash_load_pkg.sv | 19 +
 rtl/byte_word_packer.sv | 87 ++++++++
 rtl/flash_word_loader.sv | 153 +++++++++++++++
 tb/tb_flash_word_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_load_pkg.sv
// Shared definitions for the flash word loader.
// Contents:
//   WORD_BYTES_DEFAULT - bytes per packed output word
//   ADDR_W_DEFAULT     - width of flash byte address and byte count
//   load_state_e       - control FSM encoding (IDLE=0 .. DONE=4)
package flash_load_pkg;

    localparam int unsigned WORD_BYTES_DEFAULT = 32;
    localparam int unsigned ADDR_W_DEFAULT     = 24;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StRecv  = 3'd2,
        StFlush = 3'd3,
        StDone  = 3'd4
    } load_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream MSB-first into WORD_BYTES-wide words.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   byte_vld_i    - accept byte_i this cycle
//   byte_i        - byte data
//   flush_i       - left-align a partial word, zero-pad the low lanes and emit it
//   load_en_o     - one-cycle pulse: a word appears on load_data_o next cycle
//   load_data_o   - last emitted word, held until the next one
//   partial_o     - a partially filled word is pending
//   idle_o        - nothing pending (no partial word, no word in flight)
module byte_word_packer #(
    parameter int unsigned WORD_BYTES = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    byte_vld_i,
    input  logic [7:0]              byte_i,
    input  logic                    flush_i,
    output logic                    load_en_o,
    output logic [WORD_BYTES*8-1:0] load_data_o,
    output logic                    partial_o,
    output logic                    idle_o
);

    localparam int unsigned DATA_W = WORD_BYTES * 8;
    localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic              load_en_q, load_en_d;
    logic [31:0]       pad_bits;

    always_comb begin
        shift_d     = shift_q;
        word_idx_d  = word_idx_q;
        load_en_d   = 1'b0;
        load_data_d = load_data_q;
        pad_bits    = (WORD_BYTES - 32'(word_idx_q)) << 3;

        if (byte_vld_i) begin
            // First byte of a word starts from a clean register, so the completed
            // word still sitting in shift_q can be copied out this same cycle.
            if (word_idx_q == '0) begin
                shift_d = {{(DATA_W-8){1'b0}}, byte_i};
            end else begin
                shift_d = {shift_q[DATA_W-9:0], byte_i};
            end
            if (word_idx_q == IDX_W'(WORD_BYTES - 1)) begin
                word_idx_d = '0;
                load_en_d  = 1'b1;
            end else begin
                word_idx_d = word_idx_q + IDX_W'(1);
            end
        end else if (flush_i && (word_idx_q != '0)) begin
            // Move received bytes to the top lanes; zeros shift into the bottom.
            shift_d    = shift_q << pad_bits;
            word_idx_d = '0;
            load_en_d  = 1'b1;
        end

        // Word completed last cycle is still intact in shift_q.
        if (load_en_q) begin
            load_data_d = shift_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q     <= '0;
            load_data_q <= '0;
            word_idx_q  <= '0;
            load_en_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            load_data_q <= load_data_d;
            word_idx_q  <= word_idx_d;
            load_en_q   <= load_en_d;
        end
    end

    assign load_en_o   = load_en_q;
    assign load_data_o = load_data_q;
    assign partial_o   = (word_idx_q != '0);
    assign idle_o      = (word_idx_q == '0) && !load_en_q;

endmodule

// File: rtl/flash_word_loader.sv
// Weight-load responder: takes one load request, issues a single burst read
// to the SPI flash byte reader and packs the returned bytes into words.
// Ports:
//   sys_clk, sys_rst           - clock, asynchronous active-high reset
//   start/start_addr/byte_num  - load request (ignored unless idle)
//   flash_start/addr/len       - burst request to the flash byte reader
//   flash_byte_vld/flash_byte  - returned byte stream
//   load_en/load_data          - word pulse, word data one cycle later
//   busy, load_done            - request in progress / completion pulse
//   load_csum                  - 16-bit sum of accepted bytes
//                                (only with FLASH_WORD_LOADER_CHECKSUM_EN defined)
module flash_word_loader
    import flash_load_pkg::*;
#(
    parameter int unsigned WORD_BYTES = WORD_BYTES_DEFAULT,
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [ADDR_W-1:0]       byte_num,
    output logic                    flash_start,
    output logic [ADDR_W-1:0]       flash_addr,
    output logic [ADDR_W-1:0]       flash_len,
    input  logic                    flash_byte_vld,
    input  logic [7:0]              flash_byte,
    output logic                    load_en,
    output logic [WORD_BYTES*8-1:0] load_data,
    output logic                    busy,
    output logic                    load_done
`ifdef FLASH_WORD_LOADER_CHECKSUM_EN
   ,output logic [15:0]             load_csum
`endif
);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              byte_acc;
    logic              all_in;
    logic              pk_partial;
    logic              pk_idle;

    assign all_in   = (byte_cnt_q == len_q);
    // Bytes beyond the requested length are dropped here.
    assign byte_acc = (state_q == StRecv) && flash_byte_vld && !all_in;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;

        if (byte_acc) begin
            byte_cnt_d = byte_cnt_q + ADDR_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d     = start_addr;
                    len_d      = byte_num;
                    byte_cnt_d = '0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                state_d = (len_q == '0) ? StDone : StRecv;
            end
            StRecv: begin
                // Leave only once the final word has landed on load_data.
                if (all_in) begin
                    if (pk_partial) begin
                        state_d = StFlush;
                    end else if (pk_idle) begin
                        state_d = StDone;
                    end
                end
            end
            StFlush: begin
                if (pk_idle) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    byte_word_packer #(
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .byte_vld_i  (byte_acc),
        .byte_i      (flash_byte),
        .flush_i     (state_q == StFlush),
        .load_en_o   (load_en),
        .load_data_o (load_data),
        .partial_o   (pk_partial),
        .idle_o      (pk_idle)
    );

    assign flash_start = (state_q == StReq);
    assign flash_addr  = addr_q;
    assign flash_len   = len_q;
    assign busy        = (state_q == StReq) || (state_q == StRecv) || (state_q == StFlush);
    assign load_done   = (state_q == StDone);

`ifdef FLASH_WORD_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == StIdle) && start) begin
            csum_d = '0;
        end else if (byte_acc) begin
            csum_d = csum_q + 16'(flash_byte);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign load_csum = csum_q;
`endif

endmodule

// File: tb/tb_flash_word_loader.sv
// Directed bench for flash_word_loader (default 32-byte words, 24-bit address).
module tb_flash_word_loader;

    localparam int AW = 24;
    localparam int DW = 256;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] byte_num;
    logic          flash_start;
    logic [AW-1:0] flash_addr;
    logic [AW-1:0] flash_len;
    logic          flash_byte_vld;
    logic [7:0]    flash_byte;
    logic          load_en;
    logic [DW-1:0] load_data;
    logic          busy;
    logic          load_done;
`ifdef FLASH_WORD_LOADER_CHECKSUM_EN
    logic [15:0]   load_csum;
`endif

    flash_word_loader dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .start          (start),
        .start_addr     (start_addr),
        .byte_num       (byte_num),
        .flash_start    (flash_start),
        .flash_addr     (flash_addr),
        .flash_len      (flash_len),
        .flash_byte_vld (flash_byte_vld),
        .flash_byte     (flash_byte),
        .load_en        (load_en),
        .load_data      (load_data),
        .busy           (busy),
        .load_done      (load_done)
`ifdef FLASH_WORD_LOADER_CHECKSUM_EN
       ,.load_csum      (load_csum)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int tests_run = 0;
    int fails     = 0;

    // Output monitor, sampled on the falling edge.
    int            cyc = 0;
    int            fs_cnt = 0;
    int            le_cnt = 0;
    int            ld_cnt = 0;
    int            wcap = 0;
    int            last_word_cyc = 0;
    int            done_cyc = 0;
    logic          le_d = 1'b0;
    logic [DW-1:0] words [0:15];

    always @(posedge sys_clk) cyc = cyc + 1;

    always @(negedge sys_clk) begin
        if (le_d) begin
            if (wcap < 16) words[wcap] = load_data;
            wcap = wcap + 1;
            last_word_cyc = cyc;
        end
        le_d = load_en;
        if (load_en)     le_cnt = le_cnt + 1;
        if (flash_start) fs_cnt = fs_cnt + 1;
        if (load_done) begin
            ld_cnt = ld_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Pulses start for one cycle; returns in the REQ cycle.
    task automatic do_start(input logic [AW-1:0] addr, input logic [AW-1:0] num);
        start      = 1'b1;
        start_addr = addr;
        byte_num   = num;
        tick();
        start      = 1'b0;
    endtask

    // Byte i = base + i*step; start is pulsed alongside byte index ms.
    task automatic send_bytes(input int n, input int base, input int step, input int gap,
                              input int ms);
        for (int i = 0; i < n; i++) begin
            flash_byte_vld = 1'b1;
            flash_byte     = 8'(base + i * step);
            start          = (i == ms);
            tick();
            flash_byte_vld = 1'b0;
            start          = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done(input string tag, input int ld0);
        int k = 0;
        while (ld_cnt == ld0 && k < 400) begin
            tick();
            k++;
        end
        check({tag, " done_seen"}, 256'(ld_cnt != ld0), 256'd1);
        tick();
        tick();
    endtask

    int fs0, le0, ld0, w0;

    initial begin
        sys_rst        = 1'b1;
        start          = 1'b0;
        start_addr     = '0;
        byte_num       = '0;
        flash_byte_vld = 1'b0;
        flash_byte     = '0;
        tick();
        tick();
        check("rst outputs", 256'({flash_start, flash_addr, flash_len, load_en, busy, load_done}),
              256'd0);
        check("rst load_data", load_data, '0);
        sys_rst = 1'b0;
        tick();

        // 1: 64 bytes back-to-back
        fs0 = fs_cnt; le0 = le_cnt; ld0 = ld_cnt; w0 = wcap;
        do_start(24'h000100, 24'd64);
        check("t1 flash_start", 256'(flash_start), 256'd1);
        check("t1 flash_addr", 256'(flash_addr), 256'h000100);
        check("t1 flash_len", 256'(flash_len), 256'd64);
        check("t1 busy", 256'(busy), 256'd1);
        tick();
        send_bytes(64, 8'h00, 1, 0, -1);
        wait_done("t1", ld0);
        check("t1 fs_cnt", 256'(fs_cnt - fs0), 256'd1);
        check("t1 le_cnt", 256'(le_cnt - le0), 256'd2);
        check("t1 ld_cnt", 256'(ld_cnt - ld0), 256'd1);
        check("t1 word0", words[w0],
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        check("t1 word1", words[w0+1],
              256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
        check("t1 done after word", 256'(done_cyc > last_word_cyc), 256'd1);
        check("t1 busy idle", 256'(busy), 256'd0);
        check("t1 load_data held", load_data,
              256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);

        // 2: 40 bytes with 3-cycle gaps, partial last word
        fs0 = fs_cnt; le0 = le_cnt; ld0 = ld_cnt; w0 = wcap;
        do_start(24'h002000, 24'd40);
        tick();
        send_bytes(40, 8'hA0, 1, 3, -1);
        wait_done("t2", ld0);
        check("t2 le_cnt", 256'(le_cnt - le0), 256'd2);
        check("t2 word0", words[w0],
              256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf);
        check("t2 word1", words[w0+1], {64'hc0c1c2c3c4c5c6c7, 192'h0});
        check("t2 done after word", 256'(done_cyc > last_word_cyc), 256'd1);
        check("t2 ld_cnt", 256'(ld_cnt - ld0), 256'd1);

        // 3: zero-length request
        fs0 = fs_cnt; le0 = le_cnt; ld0 = ld_cnt;
        do_start(24'h003000, 24'd0);
        check("t3 req", 256'({flash_start, busy, load_done}), 256'b110);
        tick();
        check("t3 done", 256'({flash_start, busy, load_done}), 256'b001);
        tick();
        check("t3 after", 256'({flash_start, busy, load_done}), 256'b000);
        tick();
        check("t3 le_cnt", 256'(le_cnt - le0), 256'd0);
        check("t3 fs_cnt", 256'(fs_cnt - fs0), 256'd1);

        // 4: start mid-RECV ignored, 5 surplus bytes ignored
        fs0 = fs_cnt; le0 = le_cnt; ld0 = ld_cnt; w0 = wcap;
        do_start(24'h001000, 24'd40);
        tick();
        start_addr = 24'h00ABCD;
        byte_num   = 24'd8;
        send_bytes(45, 8'h40, 1, 0, 10);
        wait_done("t4", ld0);
        check("t4 fs_cnt", 256'(fs_cnt - fs0), 256'd1);
        check("t4 flash_addr", 256'(flash_addr), 256'h001000);
        check("t4 flash_len", 256'(flash_len), 256'd40);
        check("t4 le_cnt", 256'(le_cnt - le0), 256'd2);
        check("t4 word0", words[w0],
              256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f);
        check("t4 word1", words[w0+1], {64'h6061626364656667, 192'h0});

        // 5: reset after 20 of 64 bytes, then a fresh 33-byte load
        le0 = le_cnt; ld0 = ld_cnt;
        do_start(24'h004000, 24'd64);
        tick();
        send_bytes(20, 8'h00, 1, 0, -1);
        #2 sys_rst = 1'b1;
        #1;
        check("t5 rst outputs",
              256'({flash_start, flash_addr, flash_len, load_en, busy, load_done}), 256'd0);
        check("t5 rst load_data", load_data, '0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (6) tick();
        check("t5 no done", 256'(ld_cnt - ld0), 256'd0);
        check("t5 no load_en", 256'(le_cnt - le0), 256'd0);
        fs0 = fs_cnt; le0 = le_cnt; ld0 = ld_cnt; w0 = wcap;
        do_start(24'h005000, 24'd33);
        tick();
        send_bytes(33, 8'h10, 1, 0, -1);
        wait_done("t5b", ld0);
        check("t5b le_cnt", 256'(le_cnt - le0), 256'd2);
        check("t5b word0", words[w0],
              256'h101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f);
        check("t5b word1", words[w0+1], {8'h30, 248'h0});

`ifdef FLASH_WORD_LOADER_CHECKSUM_EN
        // 6: checksum of 64 x 0xFF
        ld0 = ld_cnt;
        do_start(24'h000000, 24'd64);
        check("t6 csum cleared", 256'(load_csum), 256'd0);
        tick();
        send_bytes(64, 8'hFF, 0, 0, -1);
        wait_done("t6", ld0);
        check("t6 csum", 256'(load_csum), 256'h3FC0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
